// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and latency helper for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } muldivState;

  // Cycles from the accepting edge to the edge that writes HI/LO (0 = written at accept).
  function automatic int opLatency(input logic [2:0] op, input logic divZero,
                                   input int width, input int mulLatency);
    if (op == OP_DIV || op == OP_DIVU) return divZero ? 1 : width + 1;
    if (op == OP_MTHI || op == OP_MTLO) return 0;
    return mulLatency;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring radix-2 divide iteration: shift in the next dividend bit, trial-subtract.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {remIn, quoIn[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  // The partial remainder stays below the divisor, so diff's top bit is a clean borrow flag.
  always_comb begin
    remOut = diff[WIDTH-1:0];
    quoOut = {quoIn[WIDTH-2:0], 1'b1};
    if (diff[WIDTH]) begin
      remOut = shifted[WIDTH-1:0];
      quoOut = {quoIn[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO and a busy/done handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CNT = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  muldivState           state;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   accReg;
  logic [WIDTH-1:0]     remReg, quoReg, divisorReg;
  logic                 negQuo, negRem, divZeroReg;
  logic [WIDTH-1:0]     hiReg, loReg;
  logic                 busyReg, doneReg, dbzReg;

  logic                 isSigned, aNeg, bNeg, bZero;
  logic [WIDTH-1:0]     aMag, bMag;
  logic [2*WIDTH-1:0]   aSx, bSx, prodS, prodU, mulResult;
  logic [WIDTH-1:0]     stepRem, stepQuo;
  int                   latency;

  assign isSigned = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  assign aNeg     = isSigned & a[WIDTH-1];
  assign bNeg     = isSigned & b[WIDTH-1];
  assign aMag     = aNeg ? -a : a;
  assign bMag     = bNeg ? -b : b;
  assign bZero    = (b == '0);
  assign latency  = opLatency(op, bZero, WIDTH, MUL_LATENCY);

  // Low 2*WIDTH bits of the sign-extended product equal the signed product.
  assign aSx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign bSx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign prodS = aSx * bSx;
  assign prodU = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  always_comb begin
    mulResult = prodS;
    case (op)
      OP_MULTU: mulResult = prodU;
      OP_MADD:  mulResult = {hiReg, loReg} + prodS;
      OP_MSUB:  mulResult = {hiReg, loReg} - prodS;
      default:  mulResult = prodS;
    endcase
  end

  muldiv_div_step #(.WIDTH(WIDTH)) divStep (
    .remIn  (remReg),
    .quoIn  (quoReg),
    .divisor(divisorReg),
    .remOut (stepRem),
    .quoOut (stepQuo)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      accReg     <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      negQuo     <= 1'b0;
      negRem     <= 1'b0;
      divZeroReg <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
      dbzReg     <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: hiReg <= a;
              OP_MTLO: loReg <= a;
              OP_DIV, OP_DIVU: begin
                busyReg    <= 1'b1;
                divZeroReg <= bZero;
                remReg     <= '0;
                quoReg     <= aMag;
                divisorReg <= bMag;
                negQuo     <= aNeg ^ bNeg;
                negRem     <= aNeg;
                count      <= CNT_W'(latency - 2);
                state      <= bZero ? ST_FIX : ST_DIV;
              end
              default: begin
                busyReg <= 1'b1;
                accReg  <= mulResult;
                count   <= CNT_W'(latency - 1);
                state   <= ST_MUL;
              end
            endcase
          end
        end
        ST_MUL: begin
          if (count == '0) begin
            {hiReg, loReg} <= accReg;
            doneReg        <= 1'b1;
            busyReg        <= 1'b0;
            state          <= ST_IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_DIV: begin
          remReg <= stepRem;
          quoReg <= stepQuo;
          if (count == '0) state <= ST_FIX;
          else             count <= count - 1'b1;
        end
        ST_FIX: begin
          // Magnitude quotient wraps naturally for most-negative / -1.
          if (divZeroReg) begin
            dbzReg <= 1'b1;
          end else begin
            loReg <= negQuo ? -quoReg : quoReg;
            hiReg <= negRem ? -remReg : remReg;
          end
          doneReg <= 1'b1;
          busyReg <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busyReg;
  assign done        = doneReg;
  assign div_by_zero = dbzReg;
  assign hi          = hiReg;
  assign lo          = loReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with WIDTH=32, MUL_LATENCY=4.
module tb_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit #(.WIDTH(32), .MUL_LATENCY(4)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 Clk = ~Clk;

  // Present a request before the next edge; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done (bounded), and busy cycles seen before it.
  task automatic waitDone(output int cyc, output int busyCnt, output logic dbz);
    cyc = 0; busyCnt = 0; dbz = 1'b0;
    while (cyc < 200) begin
      if (busy) busyCnt++;
      @(posedge Clk); #1;
      cyc++;
      if (done) begin
        dbz = div_by_zero;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    vectors++; if ({hi, lo} !== 64'd0) begin miscompares++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
    vectors++; if ({busy, done, div_by_zero} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero}); end
    $display("reset: hi=%h lo=%h busy=%b", hi, lo, busy);
  endtask

  task automatic test_mult;
    int cyc, bc; logic dbz;
    issue(3'd0, 32'hFFFFFFFD, 32'd7);
    waitDone(cyc, bc, dbz);
    vectors++; if (cyc !== 4) begin miscompares++; $display("FAIL mult_latency got %0d want 4", cyc); end
    vectors++; if (bc !== 4) begin miscompares++; $display("FAIL mult_busy_cycles got %0d want 4", bc); end
    vectors++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL mult_result got %h_%h want ffffffff_ffffffeb", hi, lo); end
    @(posedge Clk); #1;
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mult_done_pulse got done=%b busy=%b want 0 0", done, busy); end
    $display("MULT -3*7: cyc=%0d hi=%h lo=%h", cyc, hi, lo);
  endtask

  task automatic test_div;
    int cyc, bc; logic dbz;
    issue(3'd3, 32'd100, 32'd7);
    waitDone(cyc, bc, dbz);
    vectors++; if (cyc !== 33) begin miscompares++; $display("FAIL divu_latency got %0d want 33", cyc); end
    vectors++; if (lo !== 32'd14 || hi !== 32'd2 || dbz !== 1'b0) begin miscompares++; $display("FAIL divu_result got lo=%h hi=%h dbz=%b want e 2 0", lo, hi, dbz); end
    $display("DIVU 100/7: cyc=%0d lo=%h hi=%h", cyc, lo, hi);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    waitDone(cyc, bc, dbz);
    vectors++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_neg got lo=%h hi=%h want fffffffd ffffffff", lo, hi); end
    $display("DIV -7/2: lo=%h hi=%h", lo, hi);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    waitDone(cyc, bc, dbz);
    vectors++; if (lo !== 32'h80000000 || hi !== 32'd0 || dbz !== 1'b0) begin miscompares++; $display("FAIL div_overflow got lo=%h hi=%h dbz=%b want 80000000 0 0", lo, hi, dbz); end
    $display("DIV min/-1: lo=%h hi=%h", lo, hi);
  endtask

  task automatic test_div_zero;
    int cyc, bc; logic dbz;
    issue(3'd4, 32'h11, 32'd0);
    vectors++; if (busy !== 1'b0 || hi !== 32'h11) begin miscompares++; $display("FAIL mthi got busy=%b hi=%h want 0 11", busy, hi); end
    issue(3'd5, 32'h22, 32'd0);
    vectors++; if (busy !== 1'b0 || lo !== 32'h22) begin miscompares++; $display("FAIL mtlo got busy=%b lo=%h want 0 22", busy, lo); end
    issue(3'd2, 32'd55, 32'd0);
    waitDone(cyc, bc, dbz);
    vectors++; if (cyc !== 1 || dbz !== 1'b1) begin miscompares++; $display("FAIL divzero_flag got cyc=%0d dbz=%b want 1 1", cyc, dbz); end
    vectors++; if (hi !== 32'h11 || lo !== 32'h22) begin miscompares++; $display("FAIL divzero_hold got hi=%h lo=%h want 11 22", hi, lo); end
    @(posedge Clk); #1;
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL divzero_pulse got %b want 0", div_by_zero); end
    $display("DIV by 0: cyc=%0d hi=%h lo=%h", cyc, hi, lo);
  endtask

  task automatic test_madd_msub;
    int cyc, bc; logic dbz;
    issue(3'd4, 32'd5, 32'd0);
    issue(3'd5, 32'd6, 32'd0);
    issue(3'd6, 32'd2, 32'd3);
    waitDone(cyc, bc, dbz);
    vectors++; if (hi !== 32'd5 || lo !== 32'hC || cyc !== 4) begin miscompares++; $display("FAIL madd got hi=%h lo=%h cyc=%0d want 5 c 4", hi, lo, cyc); end
    $display("MADD 2*3 + {5,6}: hi=%h lo=%h", hi, lo);
    Reset = 1'b1; @(posedge Clk); #1; Reset = 1'b0;
    issue(3'd7, 32'd1, 32'd7);
    waitDone(cyc, bc, dbz);
    vectors++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF9) begin miscompares++; $display("FAIL msub got hi=%h lo=%h want ffffffff fffffff9", hi, lo); end
    $display("MSUB 0-1*7: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_back_to_back;
    int cyc, bc; logic dbz;
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(posedge Clk);
    #1;
    issue(3'd0, 32'd9, 32'd9);
    a = 32'd1; b = 32'd1;
    waitDone(cyc, bc, dbz);
    vectors++; if (cyc !== 29 || lo !== 32'd14 || hi !== 32'd2) begin miscompares++; $display("FAIL ignored_start got cyc=%0d lo=%h hi=%h want 29 e 2", cyc, lo, hi); end
    $display("DIVU with dropped MULT: lo=%h hi=%h", lo, hi);
    issue(3'd0, 32'd9, 32'd9);
    waitDone(cyc, bc, dbz);
    vectors++; if (cyc !== 4 || lo !== 32'h51 || hi !== 32'd0) begin miscompares++; $display("FAIL b2b_mult got cyc=%0d lo=%h hi=%h want 4 51 0", cyc, lo, hi); end
    $display("MULT 9*9 in done cycle: cyc=%0d lo=%h", cyc, lo);
  endtask

  task automatic test_reset_abort;
    int cyc, bc; logic dbz; logic sawDone;
    issue(3'd2, 32'd1000, 32'd3);
    repeat (9) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    vectors++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_state got busy=%b hi=%h lo=%h done=%b want 0 0 0 0", busy, hi, lo, done); end
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (done) sawDone = 1'b1;
    end
    vectors++; if (sawDone !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got %b want 0", sawDone); end
    op = 3'd1; a = 32'd3; b = 32'd5; start = 1'b1; Reset = 1'b1;
    @(posedge Clk); #1 start = 1'b0; Reset = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_wins got busy=%b want 0", busy); end
    issue(3'd1, 32'd3, 32'd5);
    waitDone(cyc, bc, dbz);
    vectors++; if (cyc !== 4 || lo !== 32'd15 || hi !== 32'd0) begin miscompares++; $display("FAIL post_reset_mult got cyc=%0d lo=%h hi=%h want 4 f 0", cyc, lo, hi); end
    $display("reset abort then MULTU 3*5: lo=%h", lo);
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_madd_msub;
    test_back_to_back;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It is the successor to the single-cycle HiLo register pair in the EX stage of the pipelined datapath. It adds:
- signed and unsigned iterative divide,
- configurable-latency multiply,
- multiply-accumulate,
- a busy/done handshake that the hazard unit uses to stall dependent instructions.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 4.
- MUL_LATENCY, 4, cycles from accepted MULT/MULTU/MADD/MSUB to result; must be ≥ 1.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- a  in  WIDTH  operand rs; dividend; MTHI/MTLO source.
- b  in  WIDTH  operand rt; divisor.
- busy  out  1  operation in flight; new starts are ignored.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  out  1  one-cycle pulse, coincident with done, for DIV/DIVU with b=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- **Reset:** hi=0, lo=0, busy=0, done=0, div_by_zero=0, state IDLE. Reset aborts any in-flight operation without writing HI/LO and without a done pulse.
- **States:** IDLE, MUL, DIV, FIX.
  - IDLE→MUL on start with op ∈ {0,1,6,7}.
  - IDLE→DIV on start with op ∈ {2,3} and b≠0.
  - IDLE→FIX on start with op ∈ {2,3} and b=0.
  - MUL→IDLE after MUL_LATENCY cycles.
  - DIV→FIX after WIDTH iterations.
  - FIX→IDLE after 1 cycle.
- **MTHI/MTLO:** written at the accepting edge. No busy, no done. Legal only in IDLE.
- **MULT/MULTU:** {hi,lo} ← a×b, signed or unsigned, full 2·WIDTH-bit product.
- **MADD/MSUB:** {hi,lo} ← {hi,lo} ± signed(a)×signed(b), modulo 2^(2·WIDTH). Operands and the accumulator base are captured at accept.
- **DIV/DIVU:**
  - Restoring radix-2 algorithm, one quotient bit per DIV cycle, on magnitudes.
  - FIX applies signs: quotient truncates toward zero; remainder takes the dividend's sign.
  - Results: lo ← quotient, hi ← remainder.
  - Most-negative ÷ −1 gives lo = most-negative, hi = 0 (wrap, no flag).
- **Divide by zero:** HI/LO unchanged; done=1 and div_by_zero=1.
- **Operand capture:** a, b, op and signedness are latched at accept. Input changes while busy have no effect.
- **Ignored requests:** start while busy=1 is dropped silently, with no queueing.

## Timing
- Accepting edge E0 (start=1, busy=0). Latency L:
  - MUL_LATENCY for multiply ops.
  - WIDTH+1 for DIV/DIVU.
  - 1 for divide by zero.
- busy=1 after E0 through edge E(L−1).
- At edge EL: hi/lo take the result, busy→0, done→1 for exactly one cycle.
- start may be re-asserted in the done cycle. It is accepted at that edge, so back-to-back throughput is one op per L+1 cycles.
- MTHI/MTLO: hi/lo readable the cycle after E0. busy stays 0.
- hi/lo are registered outputs. They never show intermediate partial products or remainders.
- Reset coincident with start: reset wins and the request is dropped.

## Structure
- Package muldiv_pkg contains:
  - op encodings (OP_MULT … OP_MSUB),
  - state enum (ST_IDLE, ST_MUL, ST_DIV, ST_FIX),
  - a function deriving the latency from the parameters.
- One sub-module, muldiv_div_step: combinational single restoring iteration, taking partial remainder, quotient and divisor and producing the next remainder and quotient. It is instantiated once and reused each DIV cycle.
- Multiply: product computed at accept and carried through a MUL_LATENCY-deep shift register or countdown. A retimable multiplier is acceptable.

## Test plan
Defaults: WIDTH=32, MUL_LATENCY=4.
1. MULT a=0xFFFFFFFD (−3), b=7 → after 4 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses once, busy high for exactly 4 cycles.
2. DIVU a=100, b=7 → done at E33, lo=14, hi=2. DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
3. With hi=0x11, lo=0x22: DIV b=0 → done and div_by_zero at E1, hi=0x11, lo=0x22 unchanged.
4. MTHI 5, MTLO 6, then MADD a=2 b=3 → hi=5, lo=0xC. Reset, then MSUB a=1 b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFF9.
5. DIVU 100/7 with start re-pulsed (MULT 9×9) during busy → ignored, final lo=14. MULT 9×9 issued in the done cycle → lo=0x51 four cycles later.
6. Reset asserted 10 cycles into a DIV → next cycle busy=0, hi=lo=0, no done pulse, next start accepted normally.
